// File: rtl/arb_pkg.sv
// Shared helpers for the round-robin lock arbiter: width derivation and index wrap.
package arb_pkg;

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 2;
      r = r + 1;
    end
    return r;
  endfunction

  // Width of a channel index: at least one bit even for a single channel.
  function automatic int cw_of(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  // Width of the beat counter; MAX_BEATS >= 2 keeps this at least one bit.
  function automatic int bw_of(input int max_beats);
    return clog2(max_beats);
  endfunction

  // Next channel index with an explicit wrap at n-1 (n need not be a power of two).
  function automatic int next_idx(input int i, input int n);
    return (i == n - 1) ? 0 : i + 1;
  endfunction

  // Fold an index in [0, 2n) back into [0, n).
  function automatic int wrap_idx(input int i, input int n);
    return (i >= n) ? i - n : i;
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational cyclic find-first: first set bit of valid scanning upward from start.
module rr_priority_select
  import arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int CW = cw_of(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [CW-1:0] start,
  output logic [CW-1:0] idx,
  output logic          any
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  int             off;

  // Rotate valid so that bit 0 is the start channel, then pick the lowest set bit.
  always_comb begin
    dbl = {valid, valid};
    rot = N'(dbl >> start);
    off = 0;
    any = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any && rot[k]) begin
        off = k;
        any = 1'b1;
      end
    end
    idx = CW'(wrap_idx(int'(start) + off, N));
  end

endmodule

// File: rtl/rr_lock_arbiter.sv
// N-way ready/valid arbiter with round-robin or fixed priority, burst locking
// terminated by a last flag, a beat counter and forced release on overrun.
module rr_lock_arbiter
  import arb_pkg::*;
#(
  parameter int N         = 4,
  parameter int W         = 8,
  parameter int RR        = 1,
  parameter int MAX_BEATS = 16,
  parameter int CW        = cw_of(N),
  parameter int BW        = bw_of(MAX_BEATS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    io_in_valid,
  output logic [N-1:0]    io_in_ready,
  input  logic [N*W-1:0]  io_in_bits,
  input  logic [N-1:0]    io_in_last,
  output logic            io_out_valid,
  input  logic            io_out_ready,
  output logic [W-1:0]    io_out_bits,
  output logic            io_out_last,
  output logic [CW-1:0]   io_chosen,
  output logic            io_locked,
  output logic [BW-1:0]   io_beat,
  output logic            io_overrun
);

  logic          locked_q, locked_d;
  logic [CW-1:0] lock_idx_q, lock_idx_d;
  logic [CW-1:0] ptr_q, ptr_d;
  logic [BW-1:0] beat_q, beat_d;
  logic          overrun_q, overrun_d;

  logic [CW-1:0] sel_start;
  logic [CW-1:0] sel_idx;
  logic          sel_any;
  logic [CW-1:0] chosen;
  logic          fire;

  // Fixed priority always scans from channel 0.
  assign sel_start = (RR != 0) ? ptr_q : '0;

  rr_priority_select #(
    .N  (N),
    .CW (CW)
  ) u_select (
    .valid (io_in_valid),
    .start (sel_start),
    .idx   (sel_idx),
    .any   (sel_any)
  );

  // Grant mux: a held lock overrides arbitration; the path is purely combinational.
  always_comb begin
    chosen       = locked_q ? lock_idx_q : sel_idx;
    io_out_valid = io_in_valid[chosen];
    io_out_bits  = io_in_bits[int'(chosen)*W +: W];
    io_out_last  = io_in_last[chosen];
    io_in_ready  = io_out_ready ? (N'(1) << chosen) : '0;
    fire         = io_out_valid & io_out_ready;
  end

  // State only moves on fire; last or a full burst releases the lock and advances ptr.
  always_comb begin
    locked_d   = locked_q;
    lock_idx_d = lock_idx_q;
    ptr_d      = ptr_q;
    beat_d     = beat_q;
    overrun_d  = 1'b0;
    if (fire) begin
      if (io_out_last || (beat_q == BW'(MAX_BEATS - 1))) begin
        locked_d  = 1'b0;
        beat_d    = '0;
        overrun_d = ~io_out_last;
        if (RR != 0) begin
          ptr_d = CW'(next_idx(int'(chosen), N));
        end
      end else begin
        locked_d   = 1'b1;
        lock_idx_d = chosen;
        beat_d     = beat_q + BW'(1);
      end
    end
  end

  // Lock, pointer, beat and overrun registers; reset abandons any burst in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      locked_q   <= 1'b0;
      lock_idx_q <= '0;
      ptr_q      <= '0;
      beat_q     <= '0;
      overrun_q  <= 1'b0;
    end else begin
      locked_q   <= locked_d;
      lock_idx_q <= lock_idx_d;
      ptr_q      <= ptr_d;
      beat_q     <= beat_d;
      overrun_q  <= overrun_d;
    end
  end

  assign io_chosen  = chosen;
  assign io_locked  = locked_q;
  assign io_beat    = beat_q;
  assign io_overrun = overrun_q;

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Scoreboard bench: one round-robin and one fixed-priority arbiter (MAX_BEATS=4)
// share stimulus; expectations are queued per cycle and checked on the falling edge.
module tb_rr_lock_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  in_valid;
  logic [3:0]  in_last;
  logic [31:0] in_bits;
  logic        out_ready;

  logic [3:0] rr_in_ready, fp_in_ready;
  logic       rr_out_valid, fp_out_valid;
  logic [7:0] rr_out_bits, fp_out_bits;
  logic       rr_out_last, fp_out_last;
  logic [1:0] rr_chosen, fp_chosen;
  logic       rr_locked, fp_locked;
  logic [1:0] rr_beat, fp_beat;
  logic       rr_overrun, fp_overrun;

  always #5 clk = ~clk;

  rr_lock_arbiter #(.N(4), .W(8), .RR(1), .MAX_BEATS(4)) dut_rr (
    .clk          (clk),
    .reset        (reset),
    .io_in_valid  (in_valid),
    .io_in_ready  (rr_in_ready),
    .io_in_bits   (in_bits),
    .io_in_last   (in_last),
    .io_out_valid (rr_out_valid),
    .io_out_ready (out_ready),
    .io_out_bits  (rr_out_bits),
    .io_out_last  (rr_out_last),
    .io_chosen    (rr_chosen),
    .io_locked    (rr_locked),
    .io_beat      (rr_beat),
    .io_overrun   (rr_overrun)
  );

  rr_lock_arbiter #(.N(4), .W(8), .RR(0), .MAX_BEATS(4)) dut_fp (
    .clk          (clk),
    .reset        (reset),
    .io_in_valid  (in_valid),
    .io_in_ready  (fp_in_ready),
    .io_in_bits   (in_bits),
    .io_in_last   (in_last),
    .io_out_valid (fp_out_valid),
    .io_out_ready (out_ready),
    .io_out_bits  (fp_out_bits),
    .io_out_last  (fp_out_last),
    .io_chosen    (fp_chosen),
    .io_locked    (fp_locked),
    .io_beat      (fp_beat),
    .io_overrun   (fp_overrun)
  );

  typedef struct {
    string    tag;
    bit       fp;
    logic [3:0] last;
    int       chosen;
    int       ovalid;
    int       iready;
    int       locked;
    int       beat;
    int       ovr;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   errors = 0;
  int   checks = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus and queue what the outputs must show this cycle.
  task automatic step(input string tag, input bit fp, input logic [3:0] v,
                      input logic [3:0] l, input bit r, input int ec,
                      input int elk, input int eb, input int eo);
    exp_t e;
    in_valid  = v;
    in_last   = l;
    out_ready = r;
    e.tag    = tag;
    e.fp     = fp;
    e.last   = l;
    e.chosen = ec;
    e.ovalid = int'(v[ec]);
    e.iready = r ? (1 << ec) : 0;
    e.locked = elk;
    e.beat   = eb;
    e.ovr    = eo;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    reset = 1'b1;
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      cur = sb.pop_front();
      check_eq({cur.tag, ".chosen"}, cur.fp ? int'(fp_chosen) : int'(rr_chosen), cur.chosen);
      check_eq({cur.tag, ".out_valid"}, cur.fp ? int'(fp_out_valid) : int'(rr_out_valid), cur.ovalid);
      check_eq({cur.tag, ".in_ready"}, cur.fp ? int'(fp_in_ready) : int'(rr_in_ready), cur.iready);
      check_eq({cur.tag, ".out_bits"}, cur.fp ? int'(fp_out_bits) : int'(rr_out_bits), 8'hA0 + cur.chosen);
      check_eq({cur.tag, ".out_last"}, cur.fp ? int'(fp_out_last) : int'(rr_out_last), int'(cur.last[cur.chosen]));
      check_eq({cur.tag, ".locked"}, cur.fp ? int'(fp_locked) : int'(rr_locked), cur.locked);
      check_eq({cur.tag, ".beat"}, cur.fp ? int'(fp_beat) : int'(rr_beat), cur.beat);
      check_eq({cur.tag, ".overrun"}, cur.fp ? int'(fp_overrun) : int'(rr_overrun), cur.ovr);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset     = 1'b0;
    in_valid  = '0;
    in_last   = '0;
    in_bits   = 32'hA3A2A1A0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;

    // Held in reset: lowest valid channel is shown, no state moves.
    step("rst_rr", 0, 4'b1010, 4'b1111, 1'b1, 1, 0, 0, 0);
    step("rst_fp", 1, 4'b1010, 4'b1111, 1'b1, 1, 0, 0, 0);
    reset = 1'b1;

    // Fixed priority: lowest index wins, pointer never moves.
    step("fp_a", 1, 4'b1010, 4'b1111, 1'b1, 1, 0, 0, 0);
    step("fp_idle", 1, 4'b0000, 4'b1111, 1'b1, 0, 0, 0, 0);
    step("fp_b", 1, 4'b1000, 4'b1111, 1'b1, 3, 0, 0, 0);
    step("fp_all", 1, 4'b1111, 4'b1111, 1'b1, 0, 0, 0, 0);

    // Round-robin fairness over single-beat requests.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step($sformatf("fair%0d", i), 0, 4'b1111, 4'b1111, 1'b1, i % 4, 0, 0, 0);
    end

    // Burst lock on ch2 while ch0 also requests.
    step("burst1", 0, 4'b0100, 4'b0000, 1'b1, 2, 0, 0, 0);
    step("burst2", 0, 4'b0101, 4'b0000, 1'b1, 2, 1, 1, 0);
    step("burst3", 0, 4'b0101, 4'b0100, 1'b1, 2, 1, 2, 0);
    step("after_burst", 0, 4'b1001, 4'b1111, 1'b1, 3, 0, 0, 0);
    step("wrap", 0, 4'b0001, 4'b1111, 1'b1, 0, 0, 0, 0);

    // Bubble and backpressure while locked to ch1.
    step("bub_start", 0, 4'b0010, 4'b0000, 1'b1, 1, 0, 0, 0);
    step("bub1", 0, 4'b0101, 4'b0000, 1'b1, 1, 1, 1, 0);
    step("bub2", 0, 4'b0101, 4'b0000, 1'b1, 1, 1, 1, 0);
    step("bp", 0, 4'b0111, 4'b0000, 1'b0, 1, 1, 1, 0);
    step("bub_end", 0, 4'b0111, 4'b0010, 1'b1, 1, 1, 1, 0);
    step("bub_next", 0, 4'b0111, 4'b1111, 1'b1, 2, 0, 0, 0);

    // Overrun: ch0 streams without last; forced release after the 4th fire.
    do_reset();
    step("ovr0", 0, 4'b0001, 4'b0000, 1'b1, 0, 0, 0, 0);
    step("ovr1", 0, 4'b0001, 4'b0000, 1'b1, 0, 1, 1, 0);
    step("ovr2", 0, 4'b0001, 4'b0000, 1'b1, 0, 1, 2, 0);
    step("ovr3", 0, 4'b0001, 4'b0000, 1'b1, 0, 1, 3, 0);
    step("ovr_pulse", 0, 4'b0011, 4'b0000, 1'b1, 1, 0, 0, 1);
    step("ovr_after", 0, 4'b0000, 4'b0000, 1'b0, 1, 1, 1, 0);

    // Reset asserted mid-burst on ch3 with beat=2.
    do_reset();
    step("mb0", 0, 4'b1000, 4'b0000, 1'b1, 3, 0, 0, 0);
    step("mb1", 0, 4'b1000, 4'b0000, 1'b1, 3, 1, 1, 0);
    step("mb2", 0, 4'b1000, 4'b0000, 1'b0, 3, 1, 2, 0);
    reset = 1'b0;
    step("mb_rst", 0, 4'b1111, 4'b0000, 1'b1, 0, 0, 0, 0);
    reset = 1'b1;
    step("mb_after", 0, 4'b1111, 4'b1111, 1'b1, 0, 0, 0, 0);

    @(negedge clk);
    #1;
    check_eq("sb_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
